// File: rtl/debug_step_streamer_if.sv
// FIFO-side bus for debug_step_streamer: RX FIFO pop interface plus TX FIFO push interface.
// master = the streamer, slave = the FIFO pair.
interface debug_step_streamer_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rd;
  logic       tx_full;
  logic       wr;
  logic [7:0] w_data;

  modport master (
    input  rx_data, rx_empty, tx_full,
    output rd, wr, w_data
  );

  modport slave (
    output rx_data, rx_empty, tx_full,
    input  rd, wr, w_data
  );
endinterface

// File: rtl/debug_step_streamer.sv
// Single-step/run controller for the MIPS_DLX core; snapshots debug_signal and streams it MSB first.
// Optional build macro DBG_CHECKSUM_EN: wraps the dump in an 8'hA5 header and a mod-256 data checksum.
module debug_step_streamer #(
  parameter int unsigned DEBUG_W  = 1416,
  parameter logic [7:0]  CMD_STEP = 8'h53,
  parameter logic [7:0]  CMD_RUN  = 8'h52,
  parameter logic [7:0]  CMD_HALT = 8'h48,
  parameter logic [7:0]  CMD_DUMP = 8'h44,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DEBUG_W-1:0]    debug_signal,
  debug_step_streamer_if.master fifo,
  output logic                  cpu_enable,
  output logic                  busy
);
  localparam int unsigned BYTES = DEBUG_W / 8;
  localparam int unsigned CW    = $clog2(BYTES + 2);
`ifdef DBG_CHECKSUM_EN
  localparam int unsigned TOTAL  = BYTES + 2;
  localparam logic [7:0]  HEADER = 8'hA5;
`else
  localparam int unsigned TOTAL  = BYTES;
`endif

  typedef enum logic [2:0] {IDLE, DECODE, STEP, CAPTURE, SEND, NAK} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [DEBUG_W-1:0] snap_q, snap_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         w_data_q, w_data_d;
  logic               cpu_en_q, cpu_en_d;
  logic               rd_q, rd_d;
  int unsigned        data_idx;
  logic [DEBUG_W-1:0] shifted;
  logic [7:0]         next_byte;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  // next_byte is the stream byte that follows the one currently held in w_data_q
  always_comb begin
`ifdef DBG_CHECKSUM_EN
    data_idx = 32'(cnt_q);
`else
    data_idx = 32'(cnt_q) + 1;
`endif
    shifted = snap_q << (8 * data_idx);
`ifdef DBG_CHECKSUM_EN
    next_byte = (cnt_q == CW'(BYTES)) ? sum_q + w_data_q : shifted[DEBUG_W-1 -: 8];
`else
    next_byte = shifted[DEBUG_W-1 -: 8];
`endif
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    w_data_d = w_data_q;
    cpu_en_d = cpu_en_q;
    rd_d     = 1'b0;
`ifdef DBG_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo.rx_empty) begin
          cmd_d   = fifo.rx_data;
          rd_d    = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cmd_q == CMD_RUN) begin
          cpu_en_d = 1'b1;
          state_d  = IDLE;
        end else if (cmd_q == CMD_HALT) begin
          cpu_en_d = 1'b0;
          state_d  = IDLE;
        end else if (cmd_q == CMD_DUMP) begin
          state_d = CAPTURE;
        end else if (cmd_q == CMD_STEP) begin
          // enable is registered: raising it here gives a pulse covering only the STEP cycle
          cpu_en_d = 1'b1;
          state_d  = STEP;
        end else begin
          w_data_d = NAK_BYTE;
          state_d  = NAK;
        end
      end
      STEP: begin
        cpu_en_d = 1'b0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        snap_d = debug_signal;
        cnt_d  = '0;
`ifdef DBG_CHECKSUM_EN
        w_data_d = HEADER;
        sum_d    = '0;
`else
        w_data_d = debug_signal[DEBUG_W-1 -: 8];
`endif
        state_d = SEND;
      end
      SEND: begin
        if (!fifo.tx_full) begin
          if (cnt_q == CW'(TOTAL - 1)) begin
            state_d = IDLE;
          end else begin
            cnt_d    = cnt_q + CW'(1);
            w_data_d = next_byte;
          end
`ifdef DBG_CHECKSUM_EN
          if (cnt_q != '0 && cnt_q <= CW'(BYTES)) sum_d = sum_q + w_data_q;
`endif
        end
      end
      NAK: begin
        if (!fifo.tx_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      snap_q   <= '0;
      cnt_q    <= '0;
      w_data_q <= '0;
      cpu_en_q <= 1'b0;
      rd_q     <= 1'b0;
`ifdef DBG_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      w_data_q <= w_data_d;
      cpu_en_q <= cpu_en_d;
      rd_q     <= rd_d;
`ifdef DBG_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // wr follows tx_full in the same cycle so a full FIFO is never pushed
  assign fifo.wr     = (state_q == SEND || state_q == NAK) && !fifo.tx_full;
  assign fifo.rd     = rd_q;
  assign fifo.w_data = w_data_q;
  assign cpu_enable  = cpu_en_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_debug_step_streamer.sv
// Bench for debug_step_streamer with DEBUG_W=16: modelled RX/TX FIFOs, a stepping core model,
// and expected dump streams built from the command semantics.
module tb_debug_step_streamer;
  localparam int unsigned W = 16;
  localparam logic [15:0] K = 16'h1357;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] debug_signal;
  logic         cpu_enable;
  logic         busy;

  debug_step_streamer_if bus();

  debug_step_streamer #(.DEBUG_W(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .debug_signal (debug_signal),
    .fifo         (bus),
    .cpu_enable   (cpu_enable),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // core model: value advances by K on every enabled clock
  logic [15:0] core_base = 16'h0000;
  int unsigned steps = 0;
  always @(posedge clock) if (cpu_enable) steps <= steps + 1;
  assign debug_signal = core_base + 16'(steps) * K;

  // RX FIFO model
  logic [7:0]  rx_mem [0:255];
  int unsigned rx_wp = 0;
  int unsigned rx_rp = 0;
  always @(posedge clock) if (bus.rd && rx_rp != rx_wp) rx_rp <= rx_rp + 1;
  assign bus.rx_empty = (rx_wp == rx_rp);
  assign bus.rx_data  = rx_mem[rx_rp[7:0]];

  // TX FIFO full model
  logic force_full = 1'b0;
  logic bp_rand = 1'b0;
  logic rnd_full = 1'b0;
  always @(posedge clock) begin
    #1;
    rnd_full <= ($urandom_range(0, 2) == 0);
  end
  assign bus.tx_full = bp_rand ? rnd_full : force_full;

  // monitor
  logic [7:0]  txq[$];
  int unsigned txcyc[$];
  logic [15:0] hist[$];
  int unsigned cyc = 0, rd_cnt = 0, en_cnt = 0, wr_full_cnt = 0;
  always @(negedge clock) begin
    hist.push_back(debug_signal);
    if (bus.wr) begin
      txq.push_back(bus.w_data);
      txcyc.push_back(cyc);
    end
    if (bus.wr && bus.tx_full) wr_full_cnt <= wr_full_cnt + 1;
    if (bus.rd) rd_cnt <= rd_cnt + 1;
    if (cpu_enable) en_cnt <= en_cnt + 1;
    cyc <= cyc + 1;
  end

  logic [7:0] expq[$];

  function automatic void exp_append(input logic [15:0] v);
`ifdef DBG_CHECKSUM_EN
    expq.push_back(8'hA5);
`endif
    expq.push_back(v[15:8]);
    expq.push_back(v[7:0]);
`ifdef DBG_CHECKSUM_EN
    expq.push_back(8'(v[15:8] + v[7:0]));
`endif
  endfunction

  task automatic push_cmd(input logic [7:0] b);
    rx_mem[rx_wp[7:0]] = b;
    rx_wp = rx_wp + 1;
  endtask

  task automatic set_core(input logic [15:0] v);
    core_base = v - 16'(steps) * K;
  endtask

  task automatic wait_idle(output bit ok);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while ((rx_wp != rx_rp || busy) && n < 400);
    ok = !(rx_wp != rx_rp || busy);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (cpu_enable !== 1'b0) $display("FAIL reset_cpu_enable got=%b want=0", cpu_enable); else passed++;
    checks++; if (bus.wr !== 1'b0) $display("FAIL reset_wr got=%b want=0", bus.wr); else passed++;
    checks++; if (bus.rd !== 1'b0) $display("FAIL reset_rd got=%b want=0", bus.rd); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    checks++; if (bus.w_data !== 8'h00) $display("FAIL reset_w_data got=%h want=00", bus.w_data); else passed++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock); #1;
    checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b want=0", busy); else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_step();
    int unsigned t0, r0, e0;
    int got_n;
    bit ok;
    set_core(16'hBEEF - K);
    t0 = txq.size(); r0 = rd_cnt; e0 = en_cnt;
    expq.delete(); exp_append(16'hBEEF);
    push_cmd(8'h53);
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL step_done got=timeout want=idle"); else passed++;
    checks++; if (rd_cnt - r0 !== 1) $display("FAIL step_rd_pulses got=%0d want=1", rd_cnt - r0); else passed++;
    checks++; if (en_cnt - e0 !== 1) $display("FAIL step_enable_cycles got=%0d want=1", en_cnt - e0); else passed++;
    got_n = int'(txq.size()) - int'(t0);
    checks++; if (got_n != expq.size()) $display("FAIL step_byte_count got=%0d want=%0d", got_n, expq.size()); else passed++;
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (t0 + i >= txq.size()) $display("FAIL step_byte%0d got=none want=%h", i, expq[i]);
      else if (txq[t0+i] !== expq[i]) $display("FAIL step_byte%0d got=%h want=%h", i, txq[t0+i], expq[i]);
      else passed++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL step_busy_after got=%b want=0", busy); else passed++;
  endtask

  task automatic test_step_backpressure();
    int unsigned t0, f0, n;
    int got_n;
    bit ok;
    set_core(16'hBEEF - K);
    t0 = txq.size(); f0 = wr_full_cnt;
    expq.delete(); exp_append(16'hBEEF);
    push_cmd(8'h53);
    n = 0;
    while (txq.size() == t0 && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    checks++; if (txq.size() == t0) $display("FAIL bp_first_byte got=timeout want=one byte"); else passed++;
    @(posedge clock); #1 force_full = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    checks++; if (txq.size() != t0 + 1) $display("FAIL bp_hold_bytes got=%0d want=1", txq.size() - t0); else passed++;
    force_full = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL bp_done got=timeout want=idle"); else passed++;
    checks++; if (wr_full_cnt != f0) $display("FAIL bp_wr_while_full got=%0d want=0", wr_full_cnt - f0); else passed++;
    got_n = int'(txq.size()) - int'(t0);
    checks++; if (got_n != expq.size()) $display("FAIL bp_byte_count got=%0d want=%0d", got_n, expq.size()); else passed++;
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (t0 + i >= txq.size()) $display("FAIL bp_byte%0d got=none want=%h", i, expq[i]);
      else if (txq[t0+i] !== expq[i]) $display("FAIL bp_byte%0d got=%h want=%h", i, txq[t0+i], expq[i]);
      else passed++;
    end
  endtask

  task automatic test_run_dump();
    int unsigned t0, fc;
    int got_n;
    bit ok;
    push_cmd(8'h52);
    wait_idle(ok);
    checks++; if (cpu_enable !== 1'b1) $display("FAIL run_enable got=%b want=1", cpu_enable); else passed++;
    t0 = txq.size();
    push_cmd(8'h44);
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL run_dump_done got=timeout want=idle"); else passed++;
    checks++;
    if (txq.size() <= t0) $display("FAIL run_dump_bytes got=0 want>0");
    else begin
      passed++;
      fc = txcyc[t0];
      expq.delete(); exp_append(hist[fc-1]);
      got_n = int'(txq.size()) - int'(t0);
      checks++; if (got_n != expq.size()) $display("FAIL run_dump_count got=%0d want=%0d", got_n, expq.size()); else passed++;
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (t0 + i >= txq.size()) $display("FAIL run_dump_byte%0d got=none want=%h", i, expq[i]);
        else if (txq[t0+i] !== expq[i]) $display("FAIL run_dump_byte%0d got=%h want=%h", i, txq[t0+i], expq[i]);
        else passed++;
      end
    end
    checks++; if (cpu_enable !== 1'b1) $display("FAIL run_enable_kept got=%b want=1", cpu_enable); else passed++;
    push_cmd(8'h48);
    wait_idle(ok);
    checks++; if (cpu_enable !== 1'b0) $display("FAIL halt_enable got=%b want=0", cpu_enable); else passed++;
  endtask

  task automatic test_checksum();
    int unsigned t0;
    int got_n;
    bit ok;
    logic [7:0] lit[$];
`ifdef DBG_CHECKSUM_EN
    lit = '{8'hA5, 8'hBE, 8'hEF, 8'hAD};
`else
    lit = '{8'hBE, 8'hEF};
`endif
    set_core(16'hBEEF);
    t0 = txq.size();
    push_cmd(8'h44);
    wait_idle(ok);
    got_n = int'(txq.size()) - int'(t0);
    checks++; if (got_n != lit.size()) $display("FAIL frame_count got=%0d want=%0d", got_n, lit.size()); else passed++;
    for (int i = 0; i < lit.size(); i++) begin
      checks++;
      if (t0 + i >= txq.size()) $display("FAIL frame_byte%0d got=none want=%h", i, lit[i]);
      else if (txq[t0+i] !== lit[i]) $display("FAIL frame_byte%0d got=%h want=%h", i, txq[t0+i], lit[i]);
      else passed++;
    end
  endtask

  task automatic test_unknown();
    int unsigned t0;
    logic [7:0] c;
    logic run;
    bit ok;
    bp_rand = 1'b1;
    for (int it = 0; it < 4; it++) begin
      run = 1'($urandom_range(0, 1));
      push_cmd(run ? 8'h52 : 8'h48);
      wait_idle(ok);
      do c = 8'($urandom); while (c == 8'h53 || c == 8'h52 || c == 8'h48 || c == 8'h44);
      if (it == 0) c = 8'h00;
      t0 = txq.size();
      push_cmd(c);
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL nak%0d_done got=timeout want=idle", it); else passed++;
      checks++; if (txq.size() != t0 + 1) $display("FAIL nak%0d_count got=%0d want=1", it, txq.size() - t0); else passed++;
      checks++;
      if (txq.size() <= t0) $display("FAIL nak%0d_byte got=none want=15", it);
      else if (txq[t0] !== 8'h15) $display("FAIL nak%0d_byte got=%h want=15", it, txq[t0]);
      else passed++;
      checks++; if (cpu_enable !== run) $display("FAIL nak%0d_enable got=%b want=%b", it, cpu_enable, run); else passed++;
    end
    bp_rand = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned t0, r0, e0;
    int got_n;
    logic [15:0] v1;
    bit ok;
    push_cmd(8'h48);
    wait_idle(ok);
    set_core(16'($urandom));
    v1 = core_base + 16'(steps + 1) * K;
    expq.delete(); exp_append(v1); exp_append(v1);
    t0 = txq.size(); r0 = rd_cnt; e0 = en_cnt;
    bp_rand = 1'b1;
    push_cmd(8'h53);
    push_cmd(8'h44);
    wait_idle(ok);
    bp_rand = 1'b0;
    checks++; if (!ok) $display("FAIL b2b_done got=timeout want=idle"); else passed++;
    checks++; if (rd_cnt - r0 !== 2) $display("FAIL b2b_rd_pulses got=%0d want=2", rd_cnt - r0); else passed++;
    checks++; if (en_cnt - e0 !== 1) $display("FAIL b2b_enable_cycles got=%0d want=1", en_cnt - e0); else passed++;
    got_n = int'(txq.size()) - int'(t0);
    checks++; if (got_n != expq.size()) $display("FAIL b2b_count got=%0d want=%0d", got_n, expq.size()); else passed++;
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (t0 + i >= txq.size()) $display("FAIL b2b_byte%0d got=none want=%h", i, expq[i]);
      else if (txq[t0+i] !== expq[i]) $display("FAIL b2b_byte%0d got=%h want=%h", i, txq[t0+i], expq[i]);
      else passed++;
    end
  endtask

  task automatic test_random_dumps();
    int unsigned t0, r0, e0, f0;
    int got_n;
    logic [15:0] v;
    logic is_step;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      set_core(16'($urandom));
      is_step = 1'($urandom_range(0, 1));
      bp_rand = 1'($urandom_range(0, 1));
      v = core_base + 16'(steps) * K + (is_step ? K : 16'h0000);
      expq.delete(); exp_append(v);
      t0 = txq.size(); r0 = rd_cnt; e0 = en_cnt; f0 = wr_full_cnt;
      push_cmd(is_step ? 8'h53 : 8'h44);
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL rnd%0d_done got=timeout want=idle", it); else passed++;
      checks++; if (rd_cnt - r0 !== 1) $display("FAIL rnd%0d_rd got=%0d want=1", it, rd_cnt - r0); else passed++;
      checks++; if (en_cnt - e0 !== 32'(is_step)) $display("FAIL rnd%0d_enable got=%0d want=%0d", it, en_cnt - e0, is_step); else passed++;
      checks++; if (wr_full_cnt != f0) $display("FAIL rnd%0d_wr_while_full got=%0d want=0", it, wr_full_cnt - f0); else passed++;
      got_n = int'(txq.size()) - int'(t0);
      checks++; if (got_n != expq.size()) $display("FAIL rnd%0d_count got=%0d want=%0d", it, got_n, expq.size()); else passed++;
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (t0 + i >= txq.size()) $display("FAIL rnd%0d_byte%0d got=none want=%h", it, i, expq[i]);
        else if (txq[t0+i] !== expq[i]) $display("FAIL rnd%0d_byte%0d got=%h want=%h", it, i, txq[t0+i], expq[i]);
        else passed++;
      end
    end
    bp_rand = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int unsigned t0;
    int got_n;
    logic [15:0] v;
    bit ok;
    push_cmd(8'h52);
    wait_idle(ok);
    force_full = 1'b1;
    push_cmd(8'h44);
    repeat (6) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL mid_stalled_busy got=%b want=1", busy); else passed++;
    force_full = 1'b0;
    #1;
    checks++; if (bus.wr !== 1'b1) $display("FAIL mid_wr_active got=%b want=1", bus.wr); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if (cpu_enable !== 1'b0) $display("FAIL mid_reset_enable got=%b want=0", cpu_enable); else passed++;
    checks++; if (bus.wr !== 1'b0) $display("FAIL mid_reset_wr got=%b want=0", bus.wr); else passed++;
    checks++; if (bus.rd !== 1'b0) $display("FAIL mid_reset_rd got=%b want=0", bus.rd); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got=%b want=0", busy); else passed++;
    checks++; if (bus.w_data !== 8'h00) $display("FAIL mid_reset_w_data got=%h want=00", bus.w_data); else passed++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    v = 16'($urandom);
    set_core(v);
    expq.delete(); exp_append(v);
    t0 = txq.size();
    push_cmd(8'h44);
    wait_idle(ok);
    checks++; if (cpu_enable !== 1'b0) $display("FAIL mid_after_enable got=%b want=0", cpu_enable); else passed++;
    got_n = int'(txq.size()) - int'(t0);
    checks++; if (got_n != expq.size()) $display("FAIL mid_after_count got=%0d want=%0d", got_n, expq.size()); else passed++;
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (t0 + i >= txq.size()) $display("FAIL mid_after_byte%0d got=none want=%h", i, expq[i]);
      else if (txq[t0+i] !== expq[i]) $display("FAIL mid_after_byte%0d got=%h want=%h", i, txq[t0+i], expq[i]);
      else passed++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=still running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rx_mem[i] = 8'h00;
    test_reset();
    test_step();
    test_step_backpressure();
    test_run_dump();
    test_checksum();
    test_unknown();
    test_back_to_back();
    test_random_dumps();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
